// File: rtl/aes_word_loader.sv
// Streams 32-bit key/plaintext words into the AES core's 128-bit buses, waits the
// core's fixed latency, then streams the captured ciphertext back out as four words.
module aes_word_loader #(
    parameter int unsigned LATENCY = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_is_key,
    output logic [127:0] aes_plaintext,
    output logic [127:0] aes_key,
    input  logic [127:0] aes_cipher,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         busy,
    output logic         err
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned LAT_W  = 8;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [BLK_W-1:0]    key_q, key_d;
    logic [BLK_W-1:0]    pt_q, pt_d;
    logic [BLK_W-1:0]    shift_q, shift_d;
    logic [IDX_W-1:0]    key_cnt_q, key_cnt_d;
    logic [IDX_W-1:0]    pt_cnt_q, pt_cnt_d;
    logic [IDX_W-1:0]    out_cnt_q, out_cnt_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                key_ok_q, key_ok_d;
    logic                err_q, err_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic                in_acc;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        pt_d        = pt_q;
        shift_d     = shift_q;
        key_cnt_d   = key_cnt_q;
        pt_cnt_d    = pt_cnt_q;
        out_cnt_d   = out_cnt_q;
        lat_d       = lat_q;
        key_ok_d    = key_ok_q;
        err_d       = err_q;
        out_data_d  = out_data_q;
        in_acc      = in_valid && in_ready_q;

        case (state_q)
            S_LOAD: begin
                if (in_acc) begin
                    if (in_is_key) begin
                        // A key word in the middle of a plaintext block is dropped
                        if (pt_cnt_q != IDX_W'(0)) begin
                            err_d = 1'b1;
                        end else begin
                            key_d     = {key_q[BLK_W-WORD_W-1:0], in_data};
                            key_cnt_d = key_cnt_q + IDX_W'(1);
                            if (key_cnt_q == IDX_W'(0)) key_ok_d = 1'b0;
                            if (key_cnt_q == IDX_W'(3)) key_ok_d = 1'b1;
                        end
                    end else begin
                        pt_d     = {pt_q[BLK_W-WORD_W-1:0], in_data};
                        pt_cnt_d = pt_cnt_q + IDX_W'(1);
                        if (pt_cnt_q == IDX_W'(3)) begin
                            if (key_ok_q) begin
                                state_d = S_WAIT;
                                lat_d   = LAT_W'(LATENCY - 1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_W'(0)) begin
                    shift_d    = aes_cipher;
                    out_data_d = aes_cipher[BLK_W-1 -: WORD_W];
                    out_cnt_d  = IDX_W'(0);
                    state_d    = S_DRAIN;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    // Rotate so the next word sits in the top lane
                    shift_d    = {shift_q[BLK_W-WORD_W-1:0], shift_q[BLK_W-1 -: WORD_W]};
                    out_data_d = shift_q[BLK_W-WORD_W-1 -: WORD_W];
                    out_cnt_d  = out_cnt_q + IDX_W'(1);
                    if (out_cnt_q == IDX_W'(3)) begin
                        state_d  = S_LOAD;
                        pt_cnt_d = IDX_W'(0);
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        in_ready_d  = (state_d == S_LOAD);
        out_valid_d = (state_d == S_DRAIN);
        busy_d      = (state_d != S_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            key_q       <= '0;
            pt_q        <= '0;
            shift_q     <= '0;
            key_cnt_q   <= '0;
            pt_cnt_q    <= '0;
            out_cnt_q   <= '0;
            lat_q       <= '0;
            key_ok_q    <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            shift_q     <= shift_d;
            key_cnt_q   <= key_cnt_d;
            pt_cnt_q    <= pt_cnt_d;
            out_cnt_q   <= out_cnt_d;
            lat_q       <= lat_d;
            key_ok_q    <= key_ok_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign aes_plaintext = pt_q;
    assign aes_key       = key_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_aes_word_loader.sv
// Directed bench for aes_word_loader with a fixed-latency AES stub that only
// yields a valid ciphertext when its inputs have been stable for the full latency.
module tb_aes_word_loader;

    localparam int unsigned LAT = 11;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_is_key;
    logic [127:0] aes_plaintext;
    logic [127:0] aes_key;
    logic [127:0] aes_cipher;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    aes_word_loader #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_is_key(in_is_key),
        .aes_plaintext(aes_plaintext), .aes_key(aes_key), .aes_cipher(aes_cipher),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // AES stub: known answer for the FIPS-197 inputs, a simple mix otherwise
    function automatic logic [127:0] cipher_model(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ {key[63:0], key[127:64]};
    endfunction

    logic [255:0] pipe [0:LAT-2];
    logic [255:0] tap;
    always @(posedge clk) begin
        pipe[0] <= {aes_plaintext, aes_key};
        for (int i = 1; i <= LAT - 2; i++) pipe[i] <= pipe[i-1];
    end
    assign tap        = pipe[LAT-2];
    assign aes_cipher = cipher_model(tap[255:128], tap[127:0]);

    task automatic send_word(input logic [31:0] data, input logic is_key);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        in_valid  = 1'b1;
        in_data   = data;
        in_is_key = is_key;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic is_key);
        for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], is_key);
    endtask

    task automatic recv_word(input logic [31:0] exp, input string name);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_data !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: out_data=%h valid=%0b required %h valid=1", name, out_data, out_valid, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: rdy/ov/busy/err=%b required 0000", {in_ready, out_valid, busy, err});
        end
        checks++;
        if (aes_key !== '0 || aes_plaintext !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: key=%h pt=%h od=%h required 0", aes_key, aes_plaintext, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_fips();
        int n = 0;
        send_block(FIPS_KEY, 1'b1);
        send_block(FIPS_PT, 1'b0);
        checks++;
        if (aes_key !== FIPS_KEY || aes_plaintext !== FIPS_PT) begin
            errors++;
            $display("FAIL fips_bus: key=%h pt=%h", aes_key, aes_plaintext);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fips_launch: in_ready=%0b busy=%0b required 0 1", in_ready, busy);
        end
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL fips_latency: cycles=%0d required %0d", n, LAT);
        end
        recv_word(32'h69c4e0d8, "fips_w0");
        recv_word(32'h6a7b0430, "fips_w1");
        recv_word(32'hd8cdb780, "fips_w2");
        recv_word(32'h70b4c55a, "fips_w3");
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fips_done: ov=%0b busy=%0b err=%0b rdy=%0b required 0 0 0 1",
                     out_valid, busy, err, in_ready);
        end
    endtask

    task automatic test_key_reuse();
        send_block(FIPS_PT, 1'b0);
        checks++;
        if (aes_key !== FIPS_KEY || busy !== 1'b1) begin
            errors++;
            $display("FAIL reuse_key: key=%h busy=%0b required %h 1", aes_key, busy, FIPS_KEY);
        end
        recv_word(32'h69c4e0d8, "reuse_w0");
        recv_word(32'h6a7b0430, "reuse_w1");
        recv_word(32'hd8cdb780, "reuse_w2");
        recv_word(32'h70b4c55a, "reuse_w3");
    endtask

    task automatic test_backpressure();
        logic [127:0] ct = FIPS_CT;
        int xfers = 0;
        int n = 0;
        send_block(FIPS_PT, 1'b0);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int w = 0; w < 4; w++) begin
            logic ok = 1'b1;
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                if (out_data !== ct[127-32*w -: 32] || out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0)
                    ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL bp_hold_w%0d: od=%h ov=%0b busy=%0b rdy=%0b required %h 1 1 0",
                         w, out_data, out_valid, busy, in_ready, ct[127-32*w -: 32]);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            xfers++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || xfers != 4) begin
            errors++;
            $display("FAIL bp_done: ov=%0b rdy=%0b busy=%0b xfers=%0d required 0 1 0 4",
                     out_valid, in_ready, busy, xfers);
        end
    endtask

    task automatic test_pt_before_key();
        logic saw = 1'b0;
        do_reset();
        send_block(FIPS_PT, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL nokey_err: err=%0b required 1", err);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || busy) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL nokey_launch: launched=%0b required 0", saw);
        end
        send_block(FIPS_KEY, 1'b1);
        send_block(FIPS_PT, 1'b0);
        recv_word(32'h69c4e0d8, "nokey_w0");
        recv_word(32'h6a7b0430, "nokey_w1");
        recv_word(32'hd8cdb780, "nokey_w2");
        recv_word(32'h70b4c55a, "nokey_w3");
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL nokey_sticky: err=%0b required 1", err);
        end
    endtask

    task automatic test_key_in_pt();
        do_reset();
        send_block(FIPS_KEY, 1'b1);
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL kip_pre_err: err=%0b required 0", err);
        end
        send_word(32'hdeadbeef, 1'b1);
        checks++;
        if (err !== 1'b1 || aes_key !== FIPS_KEY || busy !== 1'b0) begin
            errors++;
            $display("FAIL kip_drop: err=%0b key=%h busy=%0b required 1 %h 0", err, aes_key, busy, FIPS_KEY);
        end
        send_word(32'h33333333, 1'b0);
        send_word(32'h44444444, 1'b0);
        checks++;
        if (aes_plaintext !== 128'h11111111222222223333333344444444 || busy !== 1'b1) begin
            errors++;
            $display("FAIL kip_launch: pt=%h busy=%0b", aes_plaintext, busy);
        end
        recv_word(32'h19181b1a, "kip_w0");
        recv_word(32'h2e2f2c2d, "kip_w1");
        recv_word(32'h33323130, "kip_w2");
        recv_word(32'h40414243, "kip_w3");
    endtask

    task automatic test_reset_mid_wait();
        send_block(FIPS_PT, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, err} !== 4'b0000 || aes_key !== '0 || aes_plaintext !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: rdy/ov/busy/err=%b key=%h pt=%h od=%h required 0",
                     {in_ready, out_valid, busy, err}, aes_key, aes_plaintext, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: rdy=%0b busy=%0b required 1 0", in_ready, busy);
        end
        send_block(FIPS_PT, 1'b0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_keylost: err=%0b busy=%0b required 1 0", err, busy);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_is_key = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_fips();
        test_key_reuse();
        test_backpressure();
        test_pt_before_key();
        test_key_in_pt();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_word_loader.md
Name: aes_word_loader

Overview:
- Front-end/back-end stage wrapped around the aes encryption core.
- Accepts key and plaintext as 32-bit words over a valid/ready stream and assembles the 128-bit plaintextin/keyin buses. Holds them stable for the core's fixed latency, then captures cipertex.
- Returns the ciphertext as four 32-bit words over a valid/ready stream.
- Replaces file-driven stimulus with a streamable interface.

Parameters:
- LATENCY, 11: clock cycles from block launch to ciphertext capture. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  loader can accept a word
- in_data  input  32  input word
- in_is_key  input  1  1 = key word, 0 = plaintext word; qualified by in_valid
- aes_plaintext  output  128  drives aes plaintextin
- aes_key  output  128  drives aes keyin
- aes_cipher  input  128  from aes cipertex
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts word
- out_data  output  32  ciphertext word
- busy  output  1  high in S_WAIT or S_DRAIN
- err  output  1  sticky protocol-error flag; cleared only by reset

Behaviour:
- Reset:
  - Asynchronous, on rst_n low; all registers 0, state S_LOAD, key_ok=0.
  - Outputs: aes_plaintext=0, aes_key=0, out_valid=0, out_data=0, busy=0, err=0.
  - in_ready=0 while rst_n is low.
- Transfer: a word moves on a rising edge where valid && ready. Word order is MSW first; word 0 lands in [127:96] and word 3 in [31:0], matching %h print order.
- S_LOAD (in_ready=1):
  - Key word: shifted into the key register; key_cnt increments mod 4. key_ok clears when the first word of a key is accepted and sets when the 4th is accepted.
  - Plaintext word: shifted into the pt register; pt_cnt increments.
  - 4th plaintext word with key_ok=1: next state S_WAIT, latency counter loads LATENCY-1, in_ready drops the next cycle.
  - 4th plaintext word with key_ok=0: err<=1, pt_cnt<=0, block discarded, stay in S_LOAD.
  - Key word while pt_cnt!=0: err<=1, word dropped (counters and key register unchanged), still counted as accepted.
- Bus update rule: aes_key and aes_plaintext change only on accepted words in S_LOAD. They are held constant in S_WAIT and S_DRAIN.
- S_WAIT (in_ready=0, busy=1):
  - Counter decrements each cycle.
  - On the cycle the counter is 0: capture aes_cipher into the output shift register, set out_cnt=0, go to S_DRAIN.
  - Capture is exactly LATENCY cycles after the edge that accepted the 4th plaintext word.
- S_DRAIN (out_valid=1, busy=1):
  - out_data = shift_reg[127:96], registered.
  - On out_ready: shift left 32 bits and increment out_cnt. After the 4th transfer, out_valid<=0, pt_cnt<=0, go to S_LOAD.
  - out_valid stays high and out_data stable while out_ready is low (no drop, no duplicate).
- Key persistence: the key is retained across blocks, so subsequent blocks need only 4 plaintext words. A new 4-word key may be loaded between blocks.
- Throughput: minimum 8 + LATENCY + 4 cycles for the first block, 4 + LATENCY + 4 cycles for subsequent blocks.
- in_valid is ignored when in_ready=0. in_data and in_is_key are don't-care when in_valid=0.
- A mid-operation reset aborts any state immediately: outputs go to reset values, and the partial key or plaintext is lost.

Test Plan:
- FIPS-197 vector, LATENCY=11, with a bench aes stub returning 69c4e0d86a7b0430d8cdb78070b4c55a after 11 cycles:
  - Stimulus: key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then pt words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required: aes_key=000102030405060708090a0b0c0d0e0f and aes_plaintext=00112233445566778899aabbccddeeff.
  - Required: out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a in order, err=0.
- Key reuse: after the first test, send only 4 pt words of the same block -> identical 4 output words, aes_key unchanged.
- Backpressure: hold out_ready=0 for 7 cycles on each word -> out_data stable, exactly 4 transfers, busy=1 throughout, in_ready=0 until the last transfer.
- Plaintext before key: after reset send 4 pt words -> err=1, no S_WAIT, out_valid never asserts. Then a full key plus pt -> correct ciphertext, err stays 1.
- Key word inside plaintext: send 2 pt words, 1 key word, 2 pt words -> err=1, key unchanged, launch after the 4th pt word using pt = words 1,2,4,5.
- Reset mid-S_WAIT: assert rst_n=0 at counter=5 -> all outputs immediately at reset values. After release, in_ready=1 and key_ok=0.
